// File: rtl/axi_stream_pkg.sv
// Shared helpers for the stream arbiter: grant-index width and round-robin pointer wrap.
package axi_stream_pkg;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned wrap_inc(input int unsigned i, input int unsigned n);
    return (i + 1 >= n) ? 0 : i + 1;
  endfunction

endpackage

// File: rtl/spill_register_flushable.sv
// Two-entry spill register with synchronous flush; B holds the older beat and is presented first.
module spill_register_flushable #(
  parameter int unsigned Width  = 8,
  parameter bit          Bypass = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [Width-1:0] data_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [Width-1:0] data_o
);

  if (Bypass) begin : g_bypass
    logic unused_bypass;
    assign unused_bypass = ^{clk_i, rst_ni, flush_i};
    assign valid_o = valid_i;
    assign ready_o = ready_i;
    assign data_o  = data_i;
  end else begin : g_spill
    logic             a_full_q, a_full_d, b_full_q, b_full_d;
    logic [Width-1:0] a_data_q, a_data_d, b_data_q, b_data_d;
    logic             a_fill, a_drain, b_fill, b_drain;

    assign ready_o = ~a_full_q | ~b_full_q;
    assign valid_o = a_full_q | b_full_q;
    assign data_o  = b_full_q ? b_data_q : a_data_q;

    always_comb begin
      a_fill   = valid_i & ready_o;
      // A empties whenever B is free: straight to the output or parked in B.
      a_drain  = a_full_q & ~b_full_q;
      b_fill   = a_drain & ~ready_i;
      b_drain  = b_full_q & ready_i;
      a_full_d = a_full_q;
      b_full_d = b_full_q;
      a_data_d = a_data_q;
      b_data_d = b_data_q;
      if (a_fill | a_drain) a_full_d = a_fill;
      if (a_fill)           a_data_d = data_i;
      if (b_fill | b_drain) b_full_d = b_fill;
      if (b_fill)           b_data_d = a_data_q;
      if (flush_i) begin
        a_full_d = 1'b0;
        b_full_d = 1'b0;
      end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        a_full_q <= 1'b0;
        b_full_q <= 1'b0;
        a_data_q <= '0;
        b_data_q <= '0;
      end else begin
        a_full_q <= a_full_d;
        b_full_q <= b_full_d;
        a_data_q <= a_data_d;
        b_data_q <= b_data_d;
      end
    end
  end

endmodule

// File: rtl/stream_rr_arbiter_flushable.sv
// Round-robin arbiter sharing one registered valid/ready stream between NumInp requesters,
// with an optional grant lock for AXI-stable handshakes and a flush that drops buffered beats.
module stream_rr_arbiter_flushable
  import axi_stream_pkg::*;
#(
  parameter int unsigned NumInp    = 4,
  parameter int unsigned DataWidth = 32,
  parameter bit          LockIn    = 1'b1,
  parameter bit          Bypass    = 1'b0,
  parameter int unsigned IdxW      = idx_width(NumInp)
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        flush_i,
  input  logic [NumInp-1:0]           inp_valid_i,
  output logic [NumInp-1:0]           inp_ready_o,
  input  logic [NumInp*DataWidth-1:0] inp_data_i,
  output logic                        oup_valid_o,
  input  logic                        oup_ready_i,
  output logic [DataWidth-1:0]        oup_data_o,
  output logic [IdxW-1:0]             oup_idx_o
);

  logic [IdxW-1:0]           rr_q, rr_d, lock_idx_q, lock_idx_d, gnt;
  logic                      lock_q, lock_d;
  logic                      arb_valid, spill_valid, spill_ready, in_hs;
  logic                      srch_found;
  int unsigned               srch_idx;
  logic [DataWidth-1:0]      gnt_data;
  logic [IdxW+DataWidth-1:0] spill_in, spill_out;

  // Leading-one search over the valid vector rotated to start at rr_q.
  always_comb begin
    srch_found = 1'b0;
    srch_idx   = 0;
    gnt        = rr_q;
    for (int unsigned k = 0; k < NumInp; k++) begin
      srch_idx = 32'(rr_q) + k;
      if (srch_idx >= NumInp) srch_idx = srch_idx - NumInp;
      if (!srch_found && inp_valid_i[srch_idx[IdxW-1:0]]) begin
        srch_found = 1'b1;
        gnt        = srch_idx[IdxW-1:0];
      end
    end
    arb_valid = srch_found;
    if (lock_q) begin
      gnt       = lock_idx_q;
      arb_valid = inp_valid_i[lock_idx_q];
    end
  end

  assign gnt_data    = inp_data_i[32'(gnt)*DataWidth +: DataWidth];
  assign spill_valid = arb_valid & ~flush_i;
  assign spill_in    = {gnt, gnt_data};
  assign in_hs       = spill_valid & spill_ready;

  always_comb begin
    inp_ready_o      = '0;
    inp_ready_o[gnt] = arb_valid & spill_ready & ~flush_i;
  end

  always_comb begin
    rr_d       = rr_q;
    lock_d     = lock_q;
    lock_idx_d = lock_idx_q;
    if (in_hs) begin
      rr_d   = IdxW'(wrap_inc(32'(gnt), NumInp));
      lock_d = 1'b0;
    end else if (LockIn && arb_valid && !spill_ready && !lock_q && !flush_i) begin
      // Offered but stalled: pin the grant so the offer stays stable until accepted.
      lock_d     = 1'b1;
      lock_idx_d = gnt;
    end
    if (flush_i) lock_d = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q       <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
    end else begin
      rr_q       <= rr_d;
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
    end
  end

  spill_register_flushable #(
    .Width  (IdxW + DataWidth),
    .Bypass (Bypass)
  ) u_spill (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (flush_i),
    .valid_i (spill_valid),
    .ready_o (spill_ready),
    .data_i  (spill_in),
    .valid_o (oup_valid_o),
    .ready_i (oup_ready_i),
    .data_o  (spill_out)
  );

  assign oup_idx_o  = spill_out[DataWidth +: IdxW];
  assign oup_data_o = spill_out[DataWidth-1:0];

  // A locked requester must hold its offer until the handshake.
  lock_stable_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (lock_q && !flush_i) |-> inp_valid_i[lock_idx_q]);

endmodule

// File: tb/tb_stream_rr_arbiter_flushable.sv
// Bench: 4-input registered instance checked against a queue-based model, 3-input bypass
// instance checked by scoreboard and fairness bound under random traffic.
module tb_stream_rr_arbiter_flushable;
  localparam int unsigned DW = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          fl4, or4, ov4;
  logic [3:0]    v4, r4;
  logic [4*DW-1:0] d4;
  logic [DW-1:0] od4;
  logic [1:0]    oi4;

  logic          fl3, or3, ov3;
  logic [2:0]    v3, r3, hs3;
  logic [3*DW-1:0] d3;
  logic [DW-1:0] od3;
  logic [1:0]    oi3;

  stream_rr_arbiter_flushable #(
    .NumInp(4), .DataWidth(DW), .LockIn(1'b1), .Bypass(1'b0)
  ) dut4 (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(fl4), .inp_valid_i(v4), .inp_ready_o(r4),
    .inp_data_i(d4), .oup_valid_o(ov4), .oup_ready_i(or4), .oup_data_o(od4), .oup_idx_o(oi4)
  );

  stream_rr_arbiter_flushable #(
    .NumInp(3), .DataWidth(DW), .LockIn(1'b1), .Bypass(1'b1)
  ) dut3 (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(fl3), .inp_valid_i(v3), .inp_ready_o(r3),
    .inp_data_i(d3), .oup_valid_o(ov3), .oup_ready_i(or3), .oup_data_o(od3), .oup_idx_o(oi3)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model of the 4-input instance: pointer, lock and a 2-deep output queue.
  int              want4[4];
  int unsigned     seq = 0;
  logic [DW+1:0]   mq[$];
  int              mrr = 0;
  bit              mlock = 0;
  int              mlock_idx = 0;
  int              gq[$];
  int              oq[$];

  task automatic drive4();
    for (int i = 0; i < 4; i++) v4[i] = (want4[i] > 0);
  endtask

  task automatic cycle4(input string tag);
    int g, sz;
    bit av, hs_in, hs_out;
    logic [3:0] exp_r;
    drive4();
    #1;
    sz = mq.size();
    if (mlock) begin
      g  = mlock_idx;
      av = v4[g];
    end else begin
      av = 0;
      g  = mrr;
      for (int k = 0; k < 4; k++)
        if (!av && v4[(mrr + k) % 4]) begin
          av = 1;
          g  = (mrr + k) % 4;
        end
    end
    hs_in = av && !fl4 && (sz < 2);
    exp_r = hs_in ? 4'(1 << g) : 4'b0;
    chk({tag, "_ready"}, r4, exp_r);
    chk({tag, "_ovalid"}, ov4, sz > 0);
    if (sz > 0) begin
      chk({tag, "_oidx"}, oi4, mq[0][DW +: 2]);
      chk({tag, "_odata"}, od4, mq[0][DW-1:0]);
    end
    if (r4 != 0) gq.push_back($clog2(r4));
    if (ov4 && or4) oq.push_back(int'(oi4));
    hs_out = (sz > 0) && or4;
    if (fl4) begin
      mq.delete();
      mlock = 0;
    end else begin
      if (hs_out) void'(mq.pop_front());
      if (hs_in) begin
        mq.push_back({2'(g), d4[g*DW +: DW]});
        mrr   = (g + 1) % 4;
        mlock = 0;
      end else if (av && !mlock) begin
        mlock     = 1;
        mlock_idx = g;
      end
    end
    @(posedge clk);
    #1;
    if (hs_in) begin
      want4[g]--;
      d4[g*DW +: DW] = {8'(g), 24'(seq)};
      seq++;
    end
    drive4();
  endtask

  function automatic int qat(input int k);
    return (gq.size() > k) ? gq[k] : -1;
  endfunction

  int t1_exp[5] = '{0, 1, 2, 3, 0};
  int t3_exp[4] = '{2, 2, 2, 0};
  int sb3[3][$];
  int wait3[3];
  int served3[3];

  initial begin
    fl4 = 0; or4 = 1; v4 = '0; fl3 = 0; or3 = 1; v3 = '0; d3 = '0;
    for (int i = 0; i < 4; i++) begin
      want4[i] = 0;
      d4[i*DW +: DW] = {8'(i), 24'(seq)};
      seq++;
    end
    for (int i = 0; i < 3; i++) begin
      wait3[i] = 0;
      served3[i] = 0;
    end

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ovalid", ov4, 1'b0);
    chk("rst_odata", od4, 32'h0);
    chk("rst_oidx", oi4, 2'd0);
    chk("rst_ready", r4, 4'h0);
    rst_n = 1;

    // 1: all four valid, grants 0,1,2,3,0 and the output trails by one cycle
    want4 = '{2, 1, 1, 1};
    repeat (6) cycle4("t1");
    chk("t1_ngrants", gq.size(), 5);
    for (int k = 0; k < 5; k++) begin
      chk("t1_gnt", qat(k), t1_exp[k]);
      chk("t1_oidx_seq", (oq.size() > k) ? oq[k] : -1, t1_exp[k]);
    end

    // 2: with rr=2, inputs 1 and 3 valid: 3 first, then 1
    want4[1] = 1;
    cycle4("t2a");
    gq.delete();
    want4[1] = 1;
    want4[3] = 1;
    repeat (3) cycle4("t2");
    chk("t2_first", qat(0), 3);
    chk("t2_second", qat(1), 1);

    // 3: stalled output locks onto input 2; input 0 waits for its handshake
    repeat (2) cycle4("t3_drain");
    or4 = 0;
    gq.delete();
    want4[2] = 3;
    repeat (3) cycle4("t3_stall");
    want4[0] = 1;
    repeat (2) cycle4("t3_locked");
    chk("t3_accepted", gq.size(), 2);
    or4 = 1;
    repeat (7) cycle4("t3_release");
    chk("t3_ngrants", gq.size(), 4);
    for (int k = 0; k < 4; k++) chk("t3_gnt", qat(k), t3_exp[k]);

    // 4: both slots full and locked, flush pulsed with a fresh offer present
    or4 = 0;
    want4[1] = 2;
    repeat (2) cycle4("t4_fill");
    want4[3] = 1;
    cycle4("t4_lock");
    want4[2] = 1;
    fl4 = 1;
    cycle4("t4_flush");
    fl4 = 0;
    chk("t4_ov_after_flush", ov4, 1'b0);
    gq.delete();
    repeat (2) cycle4("t4_after");
    chk("t4_unlocked_gnt", qat(0), 2);
    chk("t4_next_gnt", qat(1), 3);
    or4 = 1;
    repeat (4) cycle4("t4_drain");

    // 5: asynchronous reset with a beat parked in slot B
    or4 = 0;
    want4[2] = 1;
    repeat (2) cycle4("t5_park");
    #1 rst_n = 0;
    #1 chk("t5_ov_async", ov4, 1'b0);
    mq.delete();
    mrr = 0;
    mlock = 0;
    #1 rst_n = 1;
    want4[1] = 1;
    want4[3] = 1;
    or4 = 1;
    gq.delete();
    repeat (4) cycle4("t5_after");
    chk("t5_first_gnt", qat(0), 1);
    chk("t5_second_gnt", qat(1), 3);

    // Random traffic on the registered instance
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < 4; i++)
        if (want4[i] == 0 && $urandom_range(3) == 0) want4[i] = int'($urandom_range(3, 1));
      or4 = ($urandom_range(3) != 0);
      fl4 = ($urandom_range(19) == 0);
      cycle4("rnd4");
    end
    fl4 = 0;
    or4 = 1;
    repeat (20) cycle4("rnd4_drain");
    chk("rnd4_empty", ov4, 1'b0);

    // 6: NumInp=3 bypass instance, random AXI-stable sources
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 3; i++)
        if (!v3[i] && $urandom_range(1) == 1) begin
          v3[i] = 1'b1;
          d3[i*DW +: DW] = {8'(i), 24'(seq)};
          seq++;
        end
      or3 = ($urandom_range(3) != 0);
      fl3 = ($urandom_range(15) == 0);
      #2;
      hs3 = r3 & v3;
      chk("r3_onehot", $onehot0(r3), 1'b1);
      chk("r3_ovalid", ov3, (|v3) && !fl3);
      chk("r3_passthru", |hs3, ov3 && or3);
      if (hs3 != 0) begin
        sb3[$clog2(hs3)].push_back(int'(d3[$clog2(hs3)*DW +: DW]));
        served3[$clog2(hs3)]++;
      end
      if (ov3 && or3) begin
        if (oi3 > 2 || sb3[oi3].size() == 0) chk("r3_oidx_valid", 1'b0, 1'b1);
        else chk("r3_data", od3, 32'(sb3[oi3].pop_front()));
      end
      for (int i = 0; i < 3; i++) begin
        if (hs3[i] || !v3[i]) wait3[i] = 0;
        else if (hs3 != 0) begin
          wait3[i]++;
          chk("r3_fair", wait3[i] < 3, 1'b1);
        end
      end
      @(posedge clk);
      #1;
      v3 = v3 & ~hs3;
    end
    for (int i = 0; i < 3; i++) chk("r3_served", served3[i] > 0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
